xor_combine_pipe: RTL

Parametrised successor to the single-stage registered XOR combiner. Combines two WIDTH-bit operands using a selectable mode: XOR, AND, OR, or running-XOR accumulate. The result passes through a DEPTH-stage pipeline with valid/ready flow control. Sits between datapath producers and consumers as a checksum/mask unit, and keeps a count of delivered results.

---
 rtl/xor_combine_pkg.sv | 29 ++
 rtl/xcp_stage.sv | 24 ++
 rtl/xor_combine_pipe.sv | 76 +++++++
 3 files changed

// File: rtl/xor_combine_pkg.sv
// Shared mode encodings and the stage-0 combine function for xor_combine_pipe.
// Callers size operands up to COMB_W and cast the result back to their own WIDTH.
package xor_combine_pkg;

   localparam logic [1:0] MODE_XOR = 2'd0;
   localparam logic [1:0] MODE_AND = 2'd1;
   localparam logic [1:0] MODE_OR  = 2'd2;
   localparam logic [1:0] MODE_ACC = 2'd3;

   // Upper bound on WIDTH; the operation is bitwise, so unused high bits fold away.
   localparam int COMB_W = 1024;

   function automatic logic [COMB_W-1:0] combine(
      input logic [1:0]        mode,
      input logic [COMB_W-1:0] a,
      input logic [COMB_W-1:0] b,
      input logic [COMB_W-1:0] acc
   );
      logic [COMB_W-1:0] r;
      case (mode)
         MODE_XOR: r = a ^ b;
         MODE_AND: r = a & b;
         MODE_OR:  r = a | b;
         default:  r = acc ^ a ^ b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/xcp_stage.sv
// One pipeline slot: WIDTH-bit data plus valid, loaded on enable, cleared by reset.
module xcp_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q_data  <= d_data;
      end
   end

endmodule

// File: rtl/xor_combine_pipe.sv
// Mode-selectable XOR/AND/OR/accumulate combiner feeding a DEPTH-stage
// valid/ready pipeline that shifts as a whole; counts delivered results.
module xor_combine_pipe
   import xor_combine_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] acc_value,
   output logic [CNT_W-1:0] out_count
);

   logic                        advance;
   logic                        accept;
   logic [WIDTH-1:0]            acc;
   logic [WIDTH-1:0]            acc_eff;
   logic [WIDTH-1:0]            s0_data;
   logic [DEPTH:0]              vld_pipe;
   logic [DEPTH:0][WIDTH-1:0]   dat_pipe;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   // Clear takes effect before a coincident ACC beat folds in its operands.
   assign acc_eff  = acc_clr ? '0 : acc;
   assign s0_data  = WIDTH'(combine(mode, COMB_W'(in_a), COMB_W'(in_b), COMB_W'(acc_eff)));

   assign vld_pipe[0] = accept;
   assign dat_pipe[0] = accept ? s0_data : '0;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      xcp_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en      (advance),
         .d_valid (vld_pipe[i]),
         .d_data  (dat_pipe[i]),
         .q_valid (vld_pipe[i+1]),
         .q_data  (dat_pipe[i+1])
      );
   end

   assign out_valid = vld_pipe[DEPTH];
   assign out_data  = dat_pipe[DEPTH];
   assign acc_value = acc;

   always_ff @(posedge clk) begin
      if (reset)
         acc <= '0;
      else if (accept && mode == MODE_ACC)
         acc <= s0_data;
      else if (acc_clr)
         acc <= '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         out_count <= '0;
      else if (out_valid && out_ready)
         out_count <= out_count + 1'b1;
   end

endmodule
